// File: rtl/nn_feeder_pkg.sv
// Shared definitions for the frame feeder: read-side FSM states and the
// width of the discarded-frame counter.
package nn_feeder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } rd_state_e;

  localparam int unsigned ErrCountWidth = 16;

endpackage

// File: rtl/nn_feeder_ram.sv
// Simple dual-port RAM: one write port, one registered read port (BRAM style).
// Ports:
//   clk          - clock
//   rst          - synchronous active-high reset of the read register only
//   we/waddr/wdata - write port
//   re/raddr     - read enable and address
//   rdata        - registered read data, 0 after reset
module nn_feeder_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2048,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/nn_frame_feeder.sv
// Input frame buffer ahead of the network stream input. Accepts a back-pressured
// sample stream with s_last markers, commits only frames of exactly FRAME_LEN
// samples, and replays each committed frame as one gap-free burst, then waits for
// nn_done before the next one (the network input cannot stall).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   s_data/s_valid/s_last    - upstream sample stream; s_ready is back-pressure
//   m_data/m_valid           - burst output to the network (no ready)
//   nn_done                  - network result pulse, releases the next frame
//   frame_err/err_count      - discard pulse and saturating discard count
//   frames_ready             - committed frames not yet sent
//   busy                     - read FSM not idle
module nn_frame_feeder
  import nn_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAME_LEN  = 784,
  parameter int unsigned DEPTH      = 2048,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = AW + 1,
  localparam int unsigned CW = $clog2(FRAME_LEN),
  localparam int unsigned FW = $clog2(DEPTH / FRAME_LEN + 1) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     nn_done,
  output logic                     frame_err,
  output logic [ErrCountWidth-1:0] err_count,
  output logic [FW-1:0]            frames_ready,
  output logic                     busy
);

  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, occupancy;
  logic [CW-1:0] in_cnt, rd_cnt;
  logic          discard;
  rd_state_e     state;

  logic accept, last_idx, wr_en, commit, rollback, go_discard, send_done;

  assign occupancy = wr_ptr - rd_ptr;
  // Discard mode drains the rest of a long frame without storing it.
  assign s_ready   = discard | (occupancy != PW'(DEPTH));
  assign accept    = s_valid & s_ready;
  assign last_idx  = (in_cnt == CW'(FRAME_LEN - 1));

  // Store a sample when it is a mid-frame sample or the correctly placed last one.
  assign wr_en      = accept & ~discard & (s_last == last_idx);
  assign commit     = accept & ~discard & s_last & last_idx;
  assign go_discard = accept & ~discard & ~s_last & last_idx;
  assign rollback   = accept & s_last & (discard | ~last_idx);

  assign send_done = (state == StSend) && (rd_cnt == CW'(FRAME_LEN - 1));
  assign busy      = (state != StIdle);

  // Write / commit / discard side.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      in_cnt     <= '0;
      discard    <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
    end else begin
      frame_err <= rollback;
      if (rollback) begin
        wr_ptr  <= commit_ptr;
        in_cnt  <= '0;
        discard <= 1'b0;
        if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (commit) begin
          commit_ptr <= wr_ptr + 1'b1;
          in_cnt     <= '0;
        end else begin
          in_cnt <= in_cnt + 1'b1;
        end
      end else if (go_discard) begin
        discard <= 1'b1;
      end
    end
  end

  // A commit and a finished burst in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_ready <= '0;
    end else if (commit && !send_done) begin
      frames_ready <= frames_ready + 1'b1;
    end else if (!commit && send_done) begin
      frames_ready <= frames_ready - 1'b1;
    end
  end

  // Read FSM; m_valid lines up with the registered RAM read issued in SEND.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      rd_ptr  <= '0;
      rd_cnt  <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (frames_ready != '0) begin
            rd_cnt <= '0;
            state  <= StSend;
          end
        end
        StSend: begin
          m_valid <= 1'b1;
          rd_ptr  <= rd_ptr + 1'b1;
          rd_cnt  <= rd_cnt + 1'b1;
          if (send_done) begin
            state <= StWait;
          end
        end
        StWait: begin
          if (nn_done) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  nn_feeder_ram #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (s_data),
    .re    (state == StSend),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (m_data)
  );

endmodule

// File: tb/tb_nn_frame_feeder.sv
// Self-checking bench for nn_frame_feeder with FRAME_LEN=4, DEPTH=8.
// Good frames push their samples onto a scoreboard queue; a negedge monitor pops
// and compares every m_valid sample and checks burst lengths.
module tb_nn_frame_feeder;

  localparam int unsigned DW = 16;
  localparam int unsigned FL = 4;
  localparam int unsigned DP = 8;
  localparam int unsigned FW = $clog2(DP / FL + 1) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          nn_done = 1'b0;
  logic          frame_err;
  logic [15:0]   err_count;
  logic [FW-1:0] frames_ready;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_out = 0;
  int run_len = 0;
  int n_err_pulses = 0;
  int ready_drops = 0;
  bit watch_ready = 1'b0;
  int base;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  nn_frame_feeder #(
    .DATA_WIDTH (DW),
    .FRAME_LEN  (FL),
    .DEPTH      (DP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .nn_done      (nn_done),
    .frame_err    (frame_err),
    .err_count    (err_count),
    .frames_ready (frames_ready),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      run_len = 0;
    end else begin
      if (m_valid) begin
        n_out++;
        run_len++;
        if (exp_q.size() == 0) begin
          check("out_unexpected", exp_q.size(), 1);
        end else begin
          check("m_data", m_data, exp_q.pop_front());
        end
      end else if (run_len != 0) begin
        check("burst_len", run_len, FL);
        run_len = 0;
      end
      if (frame_err) n_err_pulses++;
      if (watch_ready && !s_ready) ready_drops++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_sample(input logic [DW-1:0] d, input logic last);
    int cnt = 0;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    while (!s_ready && cnt < 200) begin
      step();
      cnt++;
    end
    if (!s_ready) check("s_ready_wait", s_ready, 1);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int first, input int len, input bit good);
    for (int i = 0; i < len; i++) begin
      if (good) exp_q.push_back(DW'(first + i));
      send_sample(DW'(first + i), (i == len - 1));
    end
  endtask

  task automatic wait_out(input int target);
    int cnt = 0;
    while (n_out < target && cnt < 500) begin
      step();
      cnt++;
    end
    check("wait_out", n_out, target);
  endtask

  task automatic pulse_done();
    nn_done = 1'b1;
    step();
    nn_done = 1'b0;
  endtask

  initial begin
    do_reset();
    // Reset values.
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_frames_ready", frames_ready, 0);
    check("rst_busy", busy, 0);

    // Good frame with latency check.
    base = n_out;
    send_frame(1, 4, 1'b1);
    check("t1_frames_ready_c0", frames_ready, 1);
    check("t1_m_valid_c0", m_valid, 0);
    step();
    check("t1_busy_c1", busy, 1);
    check("t1_m_valid_c1", m_valid, 0);
    step();
    check("t1_m_valid_c2", m_valid, 1);
    check("t1_m_data_c2", m_data, 1);
    wait_out(base + 4);
    check("t1_frames_ready_after", frames_ready, 0);
    repeat (3) step();
    check("t1_busy_wait", busy, 1);
    check("t1_m_valid_wait", m_valid, 0);
    pulse_done();
    check("t1_busy_idle", busy, 0);

    // Short frame then good frame.
    send_frame(5, 2, 1'b0);
    check("t2_frame_err", frame_err, 1);
    check("t2_err_count", err_count, 1);
    step();
    check("t2_frame_err_low", frame_err, 0);
    base = n_out;
    send_frame(7, 4, 1'b1);
    wait_out(base + 4);
    pulse_done();
    check("t2_err_pulses", n_err_pulses, 1);

    // Long frame then good frame; s_ready must never drop.
    watch_ready = 1'b1;
    send_frame(11, 6, 1'b0);
    watch_ready = 1'b0;
    check("t3_frame_err", frame_err, 1);
    check("t3_err_count", err_count, 2);
    check("t3_ready_drops", ready_drops, 0);
    check("t3_frames_ready", frames_ready, 0);
    base = n_out;
    send_frame(1, 4, 1'b1);
    wait_out(base + 4);
    pulse_done();
    check("t3_err_pulses", n_err_pulses, 2);

    // Back-pressure: A sent and held in WAIT, B and C fill the FIFO.
    base = n_out;
    send_frame(20, 4, 1'b1);
    send_frame(24, 4, 1'b1);
    send_frame(28, 4, 1'b1);
    wait_out(base + 4);
    check("t4_s_ready_full", s_ready, 0);
    check("t4_frames_ready", frames_ready, 2);
    check("t4_busy", busy, 1);
    fork
      send_frame(40, 4, 1'b1);
      begin
        repeat (3) step();
        check("t4_still_full", s_ready, 0);
        pulse_done();
        wait_out(base + 8);
        pulse_done();
        wait_out(base + 12);
        pulse_done();
        wait_out(base + 16);
        pulse_done();
      end
    join
    check("t4_err_count", err_count, 2);

    // Wrap-around: five frames back to back from a fresh reset.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      base = n_out;
      send_frame(100 + 4 * f, 4, 1'b1);
      wait_out(base + 4);
      pulse_done();
    end
    check("t5_err_count", err_count, 0);
    check("t5_queue_empty", exp_q.size(), 0);

    // Reset during the second cycle of a burst.
    base = n_out;
    send_frame(50, 4, 1'b1);
    wait_out(base + 1);
    check("t6_m_valid_2nd", m_valid, 1);
    rst = 1'b1;
    step();
    check("t6_m_valid", m_valid, 0);
    check("t6_frames_ready", frames_ready, 0);
    check("t6_s_ready", s_ready, 1);
    check("t6_busy", busy, 0);
    rst = 1'b0;
    repeat (6) step();
    check("t6_quiet", m_valid, 0);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
